isram_axil_rd_slave: RTL and testbench

//  Instruction SRAM read slave on the AXI-Lite read channels (AR/R) driven by the fetch stage.

---
 rtl/isram_axil_rd_slave.sv | 148 ++++++++++++++
 tb/tb_isram_axil_rd_slave.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/isram_axil_rd_slave.sv
// isram_axil_rd_slave
// Read-only instruction SRAM behind the AXI-Lite read channels (AR/R).
// One transaction in flight. Each read waits MIN_LAT cycles plus an optional
// pseudo-random extra delay, then returns one word with an OKAY/SLVERR code.
// This makes it possible to exercise a fetch stage under variable memory latency.
module isram_axil_rd_slave #(
  parameter int unsigned           DATA_WIDTH = 32,
  parameter logic [DATA_WIDTH-1:0] BASE_ADDR  = 32'h8000_0000,  // must be word aligned
  parameter int unsigned           DEPTH_LOG2 = 16,
  parameter int unsigned           MIN_LAT    = 1,              // >= 1
  parameter int unsigned           LFSR_EN    = 1,
  parameter logic [7:0]            LAT_MASK   = 8'h07,
  parameter string                 INIT_FILE  = ""
) (
  input  logic                  clk,
  input  logic                  rst,       // synchronous, active low
  input  logic [DATA_WIDTH-1:0] araddr,
  input  logic                  arvalid,
  output logic                  arready,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic                  rvalid,
  output logic [1:0]            rresp,
  input  logic                  rready,
  output logic [31:0]           rd_cnt
);

  localparam int unsigned LAT_W = 16;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_DELAY = 2'd1;
  localparam logic [1:0] S_RESP  = 2'd2;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  logic [DATA_WIDTH-1:0] mem [2**DEPTH_LOG2];

  logic [1:0]            state_q, state_d;
  logic [DATA_WIDTH-1:0] addr_q, addr_d;
  logic [LAT_W-1:0]      lat_cnt_q, lat_cnt_d;
  logic                  rvalid_q, rvalid_d;
  logic [31:0]           rd_cnt_q, rd_cnt_d;
  logic [7:0]            lfsr_q;
  logic [DATA_WIDTH-1:0] rdata_q;
  logic [1:0]            rresp_q;

  logic                  load_resp;
  logic                  lfsr_fb;
  logic [LAT_W-1:0]      lat_extra;
  logic [LAT_W-1:0]      lat_load;
  logic [DATA_WIDTH-1:0] off;
  logic                  word_ok;
  logic [DEPTH_LOG2-1:0] word_idx;

  // Latency loaded at the AR handshake uses the LFSR value present before that edge.
  assign lfsr_fb   = lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3];
  assign lat_extra = (LFSR_EN != 0) ? LAT_W'(lfsr_q & LAT_MASK) : '0;
  assign lat_load  = LAT_W'(MIN_LAT) + lat_extra;

  // Modular offset from the base; BASE_ADDR is word aligned, so off[1:0] equals araddr[1:0].
  assign off      = addr_q - BASE_ADDR;
  assign word_ok  = (off[1:0] == 2'b00) && (off[DATA_WIDTH-1:DEPTH_LOG2+2] == '0);
  assign word_idx = off[DEPTH_LOG2+1:2];

  assign arready = (state_q == S_IDLE) && rst;
  assign rvalid  = rvalid_q;
  assign rdata   = rdata_q;
  assign rresp   = rresp_q;
  assign rd_cnt  = rd_cnt_q;

  // Next-state logic for the IDLE -> DELAY -> RESP handshake sequence.
  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    lat_cnt_d = lat_cnt_q;
    rvalid_d  = rvalid_q;
    rd_cnt_d  = rd_cnt_q;
    load_resp = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (arvalid) begin
          addr_d    = araddr;
          lat_cnt_d = lat_load;
          state_d   = S_DELAY;
        end
      end
      S_DELAY: begin
        if (lat_cnt_q == LAT_W'(1)) begin
          load_resp = 1'b1;
          rvalid_d  = 1'b1;
          state_d   = S_RESP;
        end else begin
          lat_cnt_d = lat_cnt_q - LAT_W'(1);
        end
      end
      S_RESP: begin
        // Return to IDLE only; a new address is never taken in the completing cycle.
        if (rready) begin
          rvalid_d = 1'b0;
          rd_cnt_d = rd_cnt_q + 32'd1;
          state_d  = S_IDLE;
        end
      end
      default: begin
        state_d  = S_IDLE;
        rvalid_d = 1'b0;
      end
    endcase
  end

  // Control registers; reset drops any transaction in flight.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= S_IDLE;
      addr_q    <= '0;
      lat_cnt_q <= '0;
      rvalid_q  <= 1'b0;
      rd_cnt_q  <= '0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      lat_cnt_q <= lat_cnt_d;
      rvalid_q  <= rvalid_d;
      rd_cnt_q  <= rd_cnt_d;
    end
  end

  // Free-running latency LFSR, advancing every cycle out of reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      lfsr_q <= 8'hA5;
    end else begin
      lfsr_q <= {lfsr_q[6:0], lfsr_fb};
    end
  end

  // Registered memory read; errors take the same path so they keep the normal latency.
  always_ff @(posedge clk) begin
    if (!rst) begin
      rdata_q <= '0;
      rresp_q <= RESP_OKAY;
    end else if (load_resp) begin
      rdata_q <= word_ok ? mem[word_idx] : '0;
      rresp_q <= word_ok ? RESP_OKAY : RESP_SLVERR;
    end
  end

endmodule

// File: tb/tb_isram_axil_rd_slave.sv
// Bench for isram_axil_rd_slave: three instances (fixed latency 1, fixed latency 4,
// LFSR latency) driven one at a time, checked every cycle against a transaction model.
module tb_isram_axil_rd_slave;

  localparam int          ND   = 3;
  localparam int          NW   = 64;
  localparam logic [31:0] BASE = 32'h8000_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] araddr  [ND];
  logic        arvalid [ND];
  logic        rready  [ND];
  logic        arready [ND];
  logic [31:0] rdata   [ND];
  logic        rvalid  [ND];
  logic [1:0]  rresp   [ND];
  logic [31:0] rd_cnt  [ND];

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  bit          m_busy [ND];
  int          m_due  [ND];
  logic [31:0] m_data [ND];
  logic [1:0]  m_resp [ND];
  int          m_cnt  [ND];
  logic [7:0]  m_lfsr [ND];

  int          hs_cyc   [ND];
  int          obs_lat  [ND];
  logic [31:0] obs_data [ND];
  logic [1:0]  obs_resp [ND];
  logic        prev_rv  [ND];

  always #5 clk = ~clk;

  isram_axil_rd_slave #(.DEPTH_LOG2(6), .MIN_LAT(1), .LFSR_EN(0)) u_fix1 (
    .clk(clk), .rst(rst), .araddr(araddr[0]), .arvalid(arvalid[0]), .arready(arready[0]),
    .rdata(rdata[0]), .rvalid(rvalid[0]), .rresp(rresp[0]), .rready(rready[0]), .rd_cnt(rd_cnt[0]));

  isram_axil_rd_slave #(.DEPTH_LOG2(6), .MIN_LAT(4), .LFSR_EN(0)) u_fix4 (
    .clk(clk), .rst(rst), .araddr(araddr[1]), .arvalid(arvalid[1]), .arready(arready[1]),
    .rdata(rdata[1]), .rvalid(rvalid[1]), .rresp(rresp[1]), .rready(rready[1]), .rd_cnt(rd_cnt[1]));

  isram_axil_rd_slave #(.DEPTH_LOG2(6), .MIN_LAT(1), .LFSR_EN(1)) u_rnd (
    .clk(clk), .rst(rst), .araddr(araddr[2]), .arvalid(arvalid[2]), .arready(arready[2]),
    .rdata(rdata[2]), .rvalid(rvalid[2]), .rresp(rresp[2]), .rready(rready[2]), .rd_cnt(rd_cnt[2]));

  function automatic logic [31:0] img(input int i);
    return (i == 0) ? 32'h0000_0413 : (32'h1000_0093 ^ (32'(i) * 32'h0001_0101));
  endfunction

  function automatic int min_lat(input int d);
    return (d == 1) ? 4 : 1;
  endfunction

  function automatic logic [7:0] lfsr_step(input logic [7:0] v);
    return {v[6:0], v[7] ^ v[5] ^ v[4] ^ v[3]};
  endfunction

  function automatic void lookup(input logic [31:0] a, output logic [31:0] dt, output logic [1:0] rs);
    logic [31:0] o;
    o = a - BASE;
    if (a[1:0] == 2'b00 && o < 32'(4 * NW)) begin
      dt = img(int'(o >> 2));
      rs = 2'b00;
    end else begin
      dt = '0;
      rs = 2'b10;
    end
  endfunction

  task automatic check(input string name, input int d, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s dut%0d: got %h want %h (cycle %0d)", name, d, act, exp, cyc);
    end
  endtask

  // Transaction model: one outstanding read per instance, response due lat cycles after the handshake.
  initial begin
    for (int d = 0; d < ND; d++) begin
      m_busy[d] = 1'b0; m_due[d] = 0; m_data[d] = '0; m_resp[d] = '0; m_cnt[d] = 0; m_lfsr[d] = 8'hA5;
    end
    forever begin
      @(posedge clk);
      for (int d = 0; d < ND; d++) begin
        if (!rst) begin
          m_busy[d] = 1'b0;
          m_cnt[d]  = 0;
          m_lfsr[d] = 8'hA5;
        end else begin
          if (m_busy[d] && cyc >= m_due[d]) begin
            if (rready[d]) begin
              m_busy[d] = 1'b0;
              m_cnt[d]++;
            end
          end else if (!m_busy[d] && arvalid[d]) begin
            int lat;
            lat = min_lat(d) + ((d == 2) ? int'(m_lfsr[d] & 8'h07) : 0);
            m_busy[d] = 1'b1;
            m_due[d]  = cyc + 1 + lat;
            lookup(araddr[d], m_data[d], m_resp[d]);
          end
          m_lfsr[d] = lfsr_step(m_lfsr[d]);
        end
      end
      cyc++;
    end
  end

  // Per-cycle compare against the model, plus latency/data capture for the directed checks.
  initial begin
    for (int d = 0; d < ND; d++) begin
      prev_rv[d] = 1'b0; hs_cyc[d] = 0; obs_lat[d] = 0; obs_data[d] = '0; obs_resp[d] = '0;
    end
    forever begin
      @(negedge clk);
      for (int d = 0; d < ND; d++) begin
        bit exp_rv;
        exp_rv = m_busy[d] && (cyc >= m_due[d]);
        check("arready", d, 32'(arready[d]), 32'(rst && !m_busy[d]));
        check("rvalid", d, 32'(rvalid[d]), 32'(exp_rv));
        check("rd_cnt", d, rd_cnt[d], 32'(m_cnt[d]));
        if (exp_rv) begin
          check("rdata", d, rdata[d], m_data[d]);
          check("rresp", d, 32'(rresp[d]), 32'(m_resp[d]));
        end
        if (arvalid[d] && arready[d]) hs_cyc[d] = cyc + 1;
        if (rvalid[d] && !prev_rv[d]) begin
          obs_lat[d]  = cyc - hs_cyc[d];
          obs_data[d] = rdata[d];
          obs_resp[d] = rresp[d];
          if (d == 2) check("lat_in_1_8", d, 32'(obs_lat[d] >= 1 && obs_lat[d] <= 8), 32'd1);
        end
        prev_rv[d] = rvalid[d];
      end
    end
  end

  task automatic timeout_fail(input string name, input int d);
    total++;
    bad++;
    $display("FAIL %s dut%0d: timed out waiting (cycle %0d)", name, d, cyc);
  endtask

  // One read on instance d; hold = cycles rready stays low after rvalid (0 = rready high up front).
  task automatic read_tx(input int d, input logic [31:0] addr, input int hold, input bit sync);
    int n;
    if (sync) begin @(posedge clk); #2; end
    araddr[d]  = addr;
    arvalid[d] = 1'b1;
    rready[d]  = (hold == 0);
    n = 0;
    do begin @(negedge clk); n++; end while (!arready[d] && n < 64);
    if (!arready[d]) begin
      timeout_fail("ar_handshake", d);
      arvalid[d] = 1'b0;
      return;
    end
    @(posedge clk); #2;
    arvalid[d] = 1'b0;
    araddr[d]  = 32'hDEAD_BEEF;
    n = 0;
    while (!rvalid[d] && n < 300) begin @(negedge clk); n++; end
    if (!rvalid[d]) begin
      timeout_fail("rvalid_wait", d);
      rready[d] = 1'b0;
      return;
    end
    if (hold > 0) begin
      repeat (hold) @(negedge clk);
      @(posedge clk); #2;
      rready[d] = 1'b1;
      @(negedge clk);
    end
    @(posedge clk); #2;
    rready[d] = 1'b0;
    $display("tx dut%0d addr=%h lat=%0d rdata=%h rresp=%0d", d, addr, obs_lat[d], obs_data[d], obs_resp[d]);
  endtask

  task automatic directed(input int d, input logic [31:0] addr, input int hold,
                          input int lat, input logic [31:0] dat, input logic [1:0] rsp);
    read_tx(d, addr, hold, 1'b1);
    check("dir_lat", d, 32'(obs_lat[d]), 32'(lat));
    check("dir_rdata", d, obs_data[d], dat);
    check("dir_rresp", d, 32'(obs_resp[d]), 32'(rsp));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b0;
    for (int d = 0; d < ND; d++) begin
      araddr[d] = BASE; arvalid[d] = 1'b1; rready[d] = 1'b0;
    end
    for (int i = 0; i < NW; i++) begin
      u_fix1.mem[i] = img(i);
      u_fix4.mem[i] = img(i);
      u_rnd.mem[i]  = img(i);
    end

    // Reset held three cycles with arvalid asserted
    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int d = 0; d < ND; d++) begin
      check("rst_arready", d, 32'(arready[d]), 32'd0);
      check("rst_rvalid", d, 32'(rvalid[d]), 32'd0);
      check("rst_rd_cnt", d, rd_cnt[d], 32'd0);
      check("rst_rdata", d, rdata[d], 32'd0);
      check("rst_rresp", d, 32'(rresp[d]), 32'd0);
    end
    @(posedge clk); #2;
    rst = 1'b1;
    for (int d = 0; d < ND; d++) arvalid[d] = 1'b0;
    @(negedge clk);
    for (int d = 0; d < ND; d++) check("rel_arready", d, 32'(arready[d]), 32'd1);

    // Fixed latency 1, word 0
    directed(0, BASE, 0, 1, 32'h0000_0413, 2'b00);
    @(negedge clk);
    check("t2_rd_cnt", 0, rd_cnt[0], 32'd1);
    check("t2_arready", 0, 32'(arready[0]), 32'd1);

    // Fixed latency 4, word 1
    directed(1, BASE + 32'd4, 0, 4, 32'h1001_0192, 2'b00);

    // Error cases and last-word boundary, same latency as OKAY
    directed(0, 32'h8000_0002, 0, 1, 32'h0, 2'b10);
    directed(0, 32'h7FFF_FFFC, 0, 1, 32'h0, 2'b10);
    directed(0, 32'h8000_0100, 0, 1, 32'h0, 2'b10);
    directed(0, 32'h8000_00FC, 0, 1, 32'h103F_3FAC, 2'b00);
    directed(1, 32'h8000_0002, 0, 4, 32'h0, 2'b10);

    // Backpressure: rready low for 10 cycles after rvalid
    directed(1, BASE + 32'd8, 10, 4, 32'h1002_0291, 2'b00);
    @(negedge clk);
    check("t5_rd_cnt", 1, rd_cnt[1], 32'd3);

    // LFSR latency: first read right out of reset uses seed A5 -> 1 + 5
    @(posedge clk); #2;
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    rst = 1'b1;
    read_tx(2, BASE + 32'd12, 0, 1'b0);
    check("t6_first_lat", 2, 32'(obs_lat[2]), 32'd6);
    check("t6_first_rdata", 2, obs_data[2], 32'h1003_0390);
    for (int i = 1; i < 1000; i++) begin
      logic [31:0] a;
      a = BASE + 32'($urandom_range(0, 71)) * 32'd4;
      if ($urandom_range(0, 9) == 0) a = a + 32'($urandom_range(1, 3));
      if ($urandom_range(0, 29) == 0) a = BASE - 32'd4;
      read_tx(2, a, int'($urandom_range(0, 2)), 1'b1);
    end
    @(negedge clk);
    check("t6_rd_cnt", 2, rd_cnt[2], 32'd1000);

    // Reset while the read sits in DELAY: no response, count cleared
    @(posedge clk); #2;
    araddr[2] = BASE; arvalid[2] = 1'b1; rready[2] = 1'b1;
    begin
      int n;
      n = 0;
      do begin @(negedge clk); n++; end while (!arready[2] && n < 64);
      if (!arready[2]) timeout_fail("mid_delay_ar", 2);
    end
    @(posedge clk); #2;
    arvalid[2] = 1'b0;
    rst = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("mid_rvalid", 2, 32'(rvalid[2]), 32'd0);
    check("mid_rd_cnt", 2, rd_cnt[2], 32'd0);
    @(posedge clk); #2;
    rst = 1'b1;
    rready[2] = 1'b0;
    repeat (4) @(negedge clk);
    check("post_rvalid", 2, 32'(rvalid[2]), 32'd0);
    check("post_arready", 2, 32'(arready[2]), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
